pipelined_cla_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- Splits an N-bit operation into STAGES equal slices. Each pipeline stage resolves one slice with group carry-lookahead and registers the carry into the next stage.
- Sustains one operation per clock. Provides carry-out, signed overflow and zero flags.
- Datapath building block for ALU and accumulator paths; replaces the purely combinational n-bit lookahead adder where timing requires registering.

---
 rtl/pipelined_cla_addsub.sv | 157 +++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The N-bit operation is cut into STAGES slices of W = N/STAGES bits. Stage k
// adds slice k with group lookahead (GROUP bits per group, rippled between
// groups) and registers the slice carry for stage k+1. Finished low result
// bits and the still-pending high operand bits travel down together, so the
// width of each stage's registers is exactly what remains to be done.
// Legal parameters: N divisible by STAGES, W divisible by GROUP.
//
// Handshake: a transfer happens on a side when valid && ready in the same
// cycle. The whole pipe advances as one (adv = !out_valid || out_ready), so
// in_ready equals adv, nothing moves while a result is waiting, and a held
// result keeps sum/cout/ovf/zero stable until it is taken.
module pipelined_cla_addsub #(
  parameter int N      = 16,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int W    = N / STAGES;
  localparam int NGRP = W / GROUP;

  logic adv;

  // Carries c[0..W] of one slice. Inside a group every carry is the flat
  // sum-of-products lookahead from the group carry-in; groups ripple.
  function automatic logic [W:0] slice_carries(input logic [W-1:0] g,
                                               input logic [W-1:0] p,
                                               input logic         c0);
    logic [W:0] c;
    logic       acc;
    logic       pp;
    c    = '0;
    c[0] = c0;
    for (int gi = 0; gi < NGRP; gi++) begin
      for (int j = 1; j <= GROUP; j++) begin
        acc = g[gi*GROUP + j - 1];
        pp  = p[gi*GROUP + j - 1];
        for (int m = j - 2; m >= 0; m--) begin
          acc = acc | (pp & g[gi*GROUP + m]);
          pp  = pp & p[gi*GROUP + m];
        end
        c[gi*GROUP + j] = acc | (pp & c[gi*GROUP]);
      end
    end
    return c;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // LO result bits are already finished when a beat enters stage k;
    // PEND operand bits remain, with this stage's slice at the bottom.
    localparam int LO   = k * W;
    localparam int PEND = N - LO;

    logic [PEND-1:0] op_a;
    logic [PEND-1:0] op_b;
    logic            c_in;
    logic            v_in;
    logic [W-1:0]    sl_g;
    logic [W-1:0]    sl_p;
    logic [W:0]      sl_c;
    logic [W-1:0]    sl_sum;
    logic [LO+W-1:0] res_d;

    logic [LO+W-1:0] res_q;
    logic            c_q;
    logic            v_q;

    if (k == 0) begin : g_src
      // Subtraction is A + ~B + 1: B is inverted once here and the forced
      // carry-in replaces cin.
      assign op_a  = a;
      assign op_b  = sub ? ~b : b;
      assign c_in  = sub | cin;
      assign v_in  = in_valid;
      assign res_d = sl_sum;
    end else begin : g_src
      assign op_a  = g_stage[k-1].g_ops.a_q;
      assign op_b  = g_stage[k-1].g_ops.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign res_d = {sl_sum, g_stage[k-1].res_q};
    end

    assign sl_g   = op_a[W-1:0] & op_b[W-1:0];
    assign sl_p   = op_a[W-1:0] ^ op_b[W-1:0];
    assign sl_c   = slice_carries(sl_g, sl_p, c_in);
    assign sl_sum = sl_p ^ sl_c[W-1:0];

    // Valid bit, slice carry and finished result bits shift together on adv.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= sl_c[W];
        res_q <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [PEND-W-1:0] a_q;
      logic [PEND-W-1:0] b_q;

      // Carry the operand bits that later stages still have to add.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= op_a[PEND-1:W];
          b_q <= op_b[PEND-1:W];
        end
      end
    end else begin : g_flags
      logic ovf_q;
      logic zero_q;

      // Flags are registered on the same edge as the full sum they describe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= sl_c[W-1] ^ sl_c[W];
          zero_q <= ~|res_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].res_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_flags.ovf_q;
  assign zero      = g_stage[STAGES-1].g_flags.zero_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed checks on a 16-bit/2-stage
// instance, then concurrent randomized streams with backpressure on three
// other parameter sets, all compared against an arithmetic reference model.
module tb_pipelined_cla_addsub;

  localparam int N           = 16;
  localparam int STAGES      = 2;
  localparam int GROUP       = 4;
  localparam int SWEEP_BEATS = 1000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_tests        = 0;
  int n_fail         = 0;
  bit sweep_go       = 1'b0;
  int sweep_done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain (n+1)-bit arithmetic. Packed as {zero, ovf, cout, sum[31:0]}.
  function automatic logic [63:0] ref_result(input int n, input logic [63:0] av,
                                             input logic [63:0] bv, input logic cv,
                                             input logic sv);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    logic [63:0] full;
    logic [63:0] s;
    logic        c_out;
    logic        v;
    logic        z;
    mask  = (64'd1 << n) - 64'd1;
    am    = av & mask;
    bm    = sv ? (~bv & mask) : (bv & mask);
    full  = am + bm + (sv ? 64'd1 : 64'(cv));
    s     = full & mask;
    c_out = full[n];
    v     = (am[n-1] == bm[n-1]) && (s[n-1] != am[n-1]);
    z     = (s == 64'd0);
    return {29'd0, z, v, c_out, s[31:0]};
  endfunction

  function automatic logic [63:0] pack16(input logic [15:0] s, input logic c,
                                         input logic v, input logic z);
    return {29'd0, z, v, c, 16'd0, s};
  endfunction

  // ---------------- main instance (16/2/4) ----------------
  logic         m_in_valid  = 1'b0;
  logic         m_in_ready;
  logic [N-1:0] m_a         = '0;
  logic [N-1:0] m_b         = '0;
  logic         m_cin       = 1'b0;
  logic         m_sub       = 1'b0;
  logic         m_out_valid;
  logic         m_out_ready = 1'b1;
  logic [N-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;
  logic         m_zero;

  pipelined_cla_addsub #(.N(N), .STAGES(STAGES), .GROUP(GROUP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .sum(m_sum), .cout(m_cout), .ovf(m_ovf), .zero(m_zero)
  );

  function automatic logic [63:0] m_obs();
    return pack16(m_sum, m_cout, m_ovf, m_zero);
  endfunction

  // Scoreboard: expectations queued at accept, popped at output transfer.
  logic [63:0] exp_q[$];
  int          m_out_cyc_q[$];
  logic        m_hold     = 1'b0;
  logic [63:0] m_hold_val = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_hold = 1'b0;
    end else begin
      if (m_hold) begin
        check("m_stall_valid", 64'(m_out_valid), 64'd1);
        check("m_stall_hold", m_obs(), m_hold_val);
      end
      if (m_in_valid && m_in_ready)
        exp_q.push_back(ref_result(N, 64'(m_a), 64'(m_b), m_cin, m_sub));
      if (m_out_valid && m_out_ready) begin
        m_out_cyc_q.push_back(cyc);
        check("m_result_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("m_result", m_obs(), exp_q.pop_front());
      end
      m_hold     = m_out_valid && !m_out_ready;
      m_hold_val = m_obs();
    end
  end

  // ---------------- main driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic m_idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_send(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic cv, input logic sv);
    logic acc;
    int   guard;
    m_a        = av;
    m_b        = bv;
    m_cin      = cv;
    m_sub      = sv;
    m_in_valid = 1'b1;
    guard      = 0;
    do begin
      @(negedge clk);
      acc = m_in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    check("m_accept", 64'(acc), 64'd1);
  endtask

  task automatic m_send_rand();
    m_send(N'($urandom()), N'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic single_beat(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                             input logic cv, input logic sv, input logic [63:0] exp);
    m_send(av, bv, cv, sv);
    m_in_valid = 1'b0;
    check({tag, "_early"}, 64'(m_out_valid), 64'd0);
    repeat (STAGES - 1) @(posedge clk);
    #1;
    check({tag, "_valid"}, 64'(m_out_valid), 64'd1);
    check({tag, "_value"}, m_obs(), exp);
  endtask

  // ---------------- sweep instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int SN = (gi == 0) ? 8 : (gi == 1) ? 32 : 12;
    localparam int SS = (gi == 0) ? 1 : (gi == 1) ? 4 : 3;
    localparam int SG = (gi == 0) ? 4 : (gi == 1) ? 4 : 2;

    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [SN-1:0] a         = '0;
    logic [SN-1:0] b         = '0;
    logic          cin       = 1'b0;
    logic          sub       = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [SN-1:0] sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic          bp_on     = 1'b0;
    logic [63:0]   exp_q[$];
    logic          hold      = 1'b0;
    logic [63:0]   hold_val  = '0;
    int            n_out     = 0;

    pipelined_cla_addsub #(.N(SN), .STAGES(SS), .GROUP(SG)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    function automatic logic [63:0] obs();
      return {29'd0, zero, ovf, cout, 32'(sum)};
    endfunction

    // Random backpressure while the stream runs, always ready otherwise.
    always @(posedge clk) begin
      #1;
      out_ready = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          check($sformatf("sweep%0d_stall_valid", gi), 64'(out_valid), 64'd1);
          check($sformatf("sweep%0d_stall_hold", gi), obs(), hold_val);
        end
        if (in_valid && in_ready)
          exp_q.push_back(ref_result(SN, 64'(a), 64'(b), cin, sub));
        if (out_valid && out_ready) begin
          n_out++;
          check($sformatf("sweep%0d_result_expected", gi), 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) check($sformatf("sweep%0d_result", gi), obs(), exp_q.pop_front());
        end
        hold     = out_valid && !out_ready;
        hold_val = obs();
      end
    end

    initial begin
      int   guard;
      logic acc;
      wait (sweep_go);
      @(posedge clk);
      #1;
      bp_on = 1'b1;
      for (int k = 0; k < SWEEP_BEATS; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        a   = SN'($urandom());
        b   = SN'($urandom());
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0: b = a;
          1: a = '1;
          2: b = '1;
          default: ;
        endcase
        in_valid = 1'b1;
        guard    = 0;
        do begin
          @(negedge clk);
          acc = in_ready;
          @(posedge clk);
          #1;
          guard++;
        end while (!acc && guard < 64);
        check($sformatf("sweep%0d_accept", gi), 64'(acc), 64'd1);
      end
      in_valid = 1'b0;
      bp_on    = 1'b0;
      guard    = 0;
      while (exp_q.size() != 0 && guard < 200) begin
        @(posedge clk);
        guard++;
      end
      #1;
      check($sformatf("sweep%0d_drain", gi), 64'(exp_q.size()), 64'd0);
      check($sformatf("sweep%0d_count", gi), 64'(n_out), 64'(SWEEP_BEATS));
      sweep_done_cnt++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] snap;
    int          guard;

    // Reset: outputs cleared, in_ready high while in reset.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(m_out_valid), 64'd0);
    check("rst_outputs", m_obs(), 64'd0);
    check("rst_in_ready", 64'(m_in_ready), 64'd1);
    rst_n = 1'b1;
    m_idle(2);
    check("post_rst_in_ready", 64'(m_in_ready), 64'd1);

    // Directed single beats with latency check.
    single_beat("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, pack16(16'h0000, 1'b1, 1'b0, 1'b1));
    single_beat("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, pack16(16'h8000, 1'b0, 1'b1, 1'b0));
    single_beat("add_cin",  16'h1234, 16'h1111, 1'b1, 1'b0, pack16(16'h2346, 1'b0, 1'b0, 1'b0));
    single_beat("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, pack16(16'hFFFE, 1'b0, 1'b0, 1'b0));
    single_beat("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, pack16(16'h7FFF, 1'b1, 1'b1, 1'b0));
    single_beat("sub_zero", 16'h1234, 16'h1234, 1'b1, 1'b1, pack16(16'h0000, 1'b1, 1'b0, 1'b1));
    m_idle(3);

    // Eight back-to-back beats: results on eight consecutive cycles.
    m_out_cyc_q.delete();
    for (int i = 0; i < 8; i++) m_send_rand();
    m_in_valid = 1'b0;
    m_idle(STAGES + 3);
    check("stream_count", 64'(m_out_cyc_q.size()), 64'd8);
    if (m_out_cyc_q.size() == 8)
      check("stream_consecutive", 64'(m_out_cyc_q[7] - m_out_cyc_q[0]), 64'd7);

    // Backpressure mid-stream: no accept, outputs held, nothing lost.
    m_out_cyc_q.delete();
    for (int i = 0; i < 3; i++) m_send_rand();
    m_out_ready = 1'b0;
    m_a         = N'($urandom());
    m_b         = N'($urandom());
    snap        = m_obs();
    check("stall_start_valid", 64'(m_out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", 64'(m_in_ready), 64'd0);
      check("stall_outputs", m_obs(), snap);
    end
    m_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) m_send_rand();
    m_in_valid = 1'b0;
    m_idle(STAGES + 3);
    check("stall_count", 64'(m_out_cyc_q.size()), 64'd8);
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight: they must vanish.
    m_send_rand();
    m_send_rand();
    m_in_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("midrst_out_valid", 64'(m_out_valid), 64'd0);
    check("midrst_outputs", m_obs(), 64'd0);
    check("midrst_in_ready", 64'(m_in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_out_cyc_q.delete();
    m_idle(6);
    check("midrst_no_stale", 64'(m_out_cyc_q.size()), 64'd0);
    check("midrst_idle_valid", 64'(m_out_valid), 64'd0);

    // Parameter sweep with random traffic, bounded in time.
    sweep_go = 1'b1;
    guard    = 0;
    while (sweep_done_cnt < 3 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    #2;
    check("sweep_complete", 64'(sweep_done_cnt), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
